// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and the sequencer state encoding.
package alu_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_AND = 4'b0000;
    localparam logic [OP_W-1:0] OP_OR  = 4'b0001;
    localparam logic [OP_W-1:0] OP_ADD = 4'b0010;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0110;
    localparam logic [OP_W-1:0] OP_NOR = 4'b1100;
    localparam logic [OP_W-1:0] OP_MUL = 4'b1000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // MUL is the only opcode that leaves the single-cycle path.
    function automatic logic is_mul(input logic [OP_W-1:0] op);
        return op == OP_MUL;
    endfunction

endpackage

// File: rtl/alu_comb_param.sv
// Single-cycle ALU datapath (AND/OR/ADD/SUB/NOR); illegal opcodes yield zero.
// With ALU_FLAGS_EN defined it also produces raw carry/overflow for ADD/SUB.
module alu_comb_param
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] result
`ifdef ALU_FLAGS_EN
    ,
    output logic             carry,
    output logic             overflow
`endif
);

    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;

    // Subtraction shares the adder as a + ~b + 1.
    assign is_sub = (op == OP_SUB);
    assign b_eff  = is_sub ? ~b : b;

`ifdef ALU_FLAGS_EN
    logic             is_arith;
    logic [WIDTH:0]   sum_w;

    assign is_arith = (op == OP_ADD) || is_sub;
    assign sum_w    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    assign sum      = sum_w[WIDTH-1:0];
    assign carry    = is_arith & sum_w[WIDTH];
    assign overflow = is_arith & (a[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
`else
    assign sum = a + b_eff + {{(WIDTH-1){1'b0}}, is_sub};
`endif

    always_comb begin
        result = '0;
        case (op)
            OP_AND:         result = a & b;
            OP_OR:          result = a | b;
            OP_ADD, OP_SUB: result = sum;
            OP_NOR:         result = ~(a | b);
            default:        result = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq_param.sv
// Handshaked ALU: single-cycle ops via alu_comb_param, shift-add MUL over WIDTH cycles.
// Define ALU_FLAGS_EN to add registered Carry/Overflow/Negative outputs.
module alu_seq_param
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  ALUOp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero
`ifdef ALU_FLAGS_EN
    ,
    output logic             Carry,
    output logic             Overflow,
    output logic             Negative
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    state_t           state, state_n;
    logic             out_valid_n;
    logic [WIDTH-1:0] result_n;
    logic             zero_n;
    logic [WIDTH-1:0] acc, acc_n;
    logic [WIDTH-1:0] ma, ma_n;
    logic [WIDTH-1:0] mb, mb_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] mul_sum;
    logic [WIDTH-1:0] comb_result;
    logic             accept;

`ifdef ALU_FLAGS_EN
    logic             comb_carry;
    logic             comb_overflow;
    logic             carry_n;
    logic             overflow_n;
    logic             negative_n;
`endif

    alu_comb_param #(
        .WIDTH (WIDTH)
    ) u_comb (
        .a        (a),
        .b        (b),
        .op       (ALUOp),
        .result   (comb_result)
`ifdef ALU_FLAGS_EN
        ,
        .carry    (comb_carry),
        .overflow (comb_overflow)
`endif
    );

    // Next-state, handshake and datapath update.
    always_comb begin
        state_n     = state;
        out_valid_n = out_valid;
        result_n    = Result;
        zero_n      = Zero;
        acc_n       = acc;
        ma_n        = ma;
        mb_n        = mb;
        cnt_n       = cnt;
        in_ready    = 1'b0;
        accept      = 1'b0;
        mul_sum     = acc + (mb[0] ? ma : '0);
`ifdef ALU_FLAGS_EN
        carry_n     = Carry;
        overflow_n  = Overflow;
        negative_n  = Negative;
`endif

        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
            end
            S_MUL: begin
                acc_n = mul_sum;
                ma_n  = ma << 1;
                mb_n  = mb >> 1;
                cnt_n = cnt + CNT_W'(1);
                // Last step: publish the accumulator including this step's addend.
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_n     = S_DONE;
                    out_valid_n = 1'b1;
                    result_n    = mul_sum;
                    zero_n      = (mul_sum == '0);
`ifdef ALU_FLAGS_EN
                    carry_n     = 1'b0;
                    overflow_n  = 1'b0;
                    negative_n  = mul_sum[WIDTH-1];
`endif
                end
            end
            S_DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    state_n     = S_IDLE;
                    out_valid_n = 1'b0;
                end
            end
            default: begin
                state_n     = S_IDLE;
                out_valid_n = 1'b0;
            end
        endcase

        // A new accept overrides the consume path above.
        accept = in_valid && in_ready;
        if (accept) begin
            if (is_mul(ALUOp)) begin
                state_n     = S_MUL;
                out_valid_n = 1'b0;
                acc_n       = '0;
                ma_n        = a;
                mb_n        = b;
                cnt_n       = '0;
            end else begin
                state_n     = S_DONE;
                out_valid_n = 1'b1;
                result_n    = comb_result;
                zero_n      = (comb_result == '0);
`ifdef ALU_FLAGS_EN
                carry_n     = comb_carry;
                overflow_n  = comb_overflow;
                negative_n  = comb_result[WIDTH-1];
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            Result    <= '0;
            Zero      <= 1'b0;
            acc       <= '0;
            ma        <= '0;
            mb        <= '0;
            cnt       <= '0;
`ifdef ALU_FLAGS_EN
            Carry     <= 1'b0;
            Overflow  <= 1'b0;
            Negative  <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            out_valid <= out_valid_n;
            Result    <= result_n;
            Zero      <= zero_n;
            acc       <= acc_n;
            ma        <= ma_n;
            mb        <= mb_n;
            cnt       <= cnt_n;
`ifdef ALU_FLAGS_EN
            Carry     <= carry_n;
            Overflow  <= overflow_n;
            Negative  <= negative_n;
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq_param.sv
// Self-checking bench for alu_seq_param at WIDTH=64 and WIDTH=8 (flags when ALU_FLAGS_EN).
`timescale 1ns/1ps
module tb_alu_seq_param;
    import alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        v64, ir64, ov64, rdy64, z64;
    logic [63:0] a64, b64, r64;
    logic [3:0]  op64;
    logic        v8, ir8, ov8, rdy8, z8;
    logic [7:0]  a8, b8, r8;
    logic [3:0]  op8;
`ifdef ALU_FLAGS_EN
    logic        c64, o64, n64, c8, o8, n8;
`endif

    int checks = 0;
    int errors = 0;

    alu_seq_param #(.WIDTH(64)) dut64 (
        .clk(clk), .reset_n(reset_n), .in_valid(v64), .in_ready(ir64),
        .a(a64), .b(b64), .ALUOp(op64), .out_valid(ov64), .out_ready(rdy64),
        .Result(r64), .Zero(z64)
`ifdef ALU_FLAGS_EN
        , .Carry(c64), .Overflow(o64), .Negative(n64)
`endif
    );

    alu_seq_param #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .in_valid(v8), .in_ready(ir8),
        .a(a8), .b(b8), .ALUOp(op8), .out_valid(ov8), .out_ready(rdy8),
        .Result(r8), .Zero(z8)
`ifdef ALU_FLAGS_EN
        , .Carry(c8), .Overflow(o8), .Negative(n8)
`endif
    );

    typedef struct {
        int          w;
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic        z;
        int          lat;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic truncated to the operand width.
    function automatic logic [63:0] ref_result(input int w, input logic [3:0] op,
                                               input logic [63:0] x, input logic [63:0] y);
        logic [63:0] r;
        logic [63:0] mask;
        case (op)
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_ADD:  r = x + y;
            OP_SUB:  r = x - y;
            OP_NOR:  r = ~(x | y);
            OP_MUL:  r = x * y;
            default: r = 64'd0;
        endcase
        mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        return r & mask;
    endfunction

`ifdef ALU_FLAGS_EN
    // Returns {carry, overflow, negative} from operand/result sign rules.
    function automatic logic [2:0] ref_flags(input int w, input logic [3:0] op,
                                             input logic [63:0] x, input logic [63:0] y);
        logic [63:0] r;
        logic [64:0] full;
        logic        c, o, sx, sy, sr;
        r    = ref_result(w, op, x, y);
        full = {1'b0, x} + {1'b0, y};
        sx   = x[w-1];
        sy   = y[w-1];
        sr   = r[w-1];
        c    = 1'b0;
        o    = 1'b0;
        if (op == OP_ADD) begin
            c = full[w];
            o = (sx == sy) && (sr != sx);
        end else if (op == OP_SUB) begin
            c = (x >= y);
            o = (sx != sy) && (sr != sx);
        end
        return {c, o, sr};
    endfunction
`endif

    // lat = rising edges after the accept edge until out_valid is observed.
    task automatic run64(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y,
                         output logic [63:0] res, output logic z, output int lat);
        int guard = 0;
        op64 = op; a64 = x; b64 = y; v64 = 1'b1; rdy64 = 1'b1;
        #1;
        while (!ir64 && guard < 200) begin @(negedge clk); #1; guard++; end
        if (guard >= 200) begin
            checks++; errors++;
            $display("FAIL run64_accept in_ready=0 required=1");
        end
        @(posedge clk);
        @(negedge clk); #1;
        v64 = 1'b0;
        lat = 0;
        while (!ov64 && lat < 200) begin @(negedge clk); #1; lat++; end
        res = r64; z = z64;
    endtask

    task automatic run8(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y,
                        output logic [7:0] res, output logic z, output int lat);
        int guard = 0;
        op8 = op; a8 = x; b8 = y; v8 = 1'b1; rdy8 = 1'b1;
        #1;
        while (!ir8 && guard < 200) begin @(negedge clk); #1; guard++; end
        if (guard >= 200) begin
            checks++; errors++;
            $display("FAIL run8_accept in_ready=0 required=1");
        end
        @(posedge clk);
        @(negedge clk); #1;
        v8 = 1'b0;
        lat = 0;
        while (!ov8 && lat < 200) begin @(negedge clk); #1; lat++; end
        res = r8; z = z8;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [63:0] res, x, y, exp;
        logic [7:0]  res8, x8, y8;
        logic        z;
        int          lat;
        logic [3:0]  op;

        reset_n = 1'b0;
        v64 = 1'b0; a64 = '0; b64 = '0; op64 = '0; rdy64 = 1'b1;
        v8  = 1'b0; a8  = '0; b8  = '0; op8  = '0; rdy8  = 1'b1;

        vt[0]  = '{64, OP_AND, 64'h0000000AB000000F, 64'h0002300000000F0F, 64'h000000000000000F, 1'b0, 0};
        vt[1]  = '{64, OP_OR,  64'h0000000AB000000F, 64'h0002300000000F0F, 64'h0002300AB0000F0F, 1'b0, 0};
        vt[2]  = '{64, OP_ADD, 64'h0000000AB000000F, 64'h0002300000000F0F, 64'h0002300AB0000F1E, 1'b0, 0};
        vt[3]  = '{64, OP_SUB, 64'd5, 64'd5, 64'd0, 1'b1, 0};
        vt[4]  = '{64, OP_NOR, 64'd0, 64'd0, {64{1'b1}}, 1'b0, 0};
        vt[5]  = '{64, 4'b1111, 64'h0000000AB000000F, 64'h0002300000000F0F, 64'd0, 1'b1, 0};
        vt[6]  = '{64, OP_MUL, 64'd7, 64'd6, 64'd42, 1'b0, 64};
        vt[7]  = '{64, OP_MUL, 64'd0, 64'd123, 64'd0, 1'b1, 64};
        vt[8]  = '{8,  OP_MUL, 64'hFF, 64'h02, 64'hFE, 1'b0, 8};
        vt[9]  = '{8,  OP_MUL, 64'hFF, 64'hFF, 64'h01, 1'b0, 8};
        vt[10] = '{8,  OP_SUB, 64'h00, 64'h01, 64'hFF, 1'b0, 0};

        #2;
        chk("reset_out_valid", 64'(ov64), 64'd0);
        chk("reset_result", r64, 64'd0);
        chk("reset_zero", 64'(z64), 64'd0);
        chk("reset_in_ready", 64'(ir64), 64'd1);
        chk("reset_out_valid8", 64'(ov8), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            if (vt[i].w == 64) begin
                run64(vt[i].op, vt[i].a, vt[i].b, res, z, lat);
            end else begin
                run8(vt[i].op, vt[i].a[7:0], vt[i].b[7:0], res8, z, lat);
                res = {56'd0, res8};
            end
            chk($sformatf("vec%0d_result", i), res, vt[i].res);
            chk($sformatf("vec%0d_zero", i), 64'(z), 64'(vt[i].z));
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vt[i].lat));
        end

`ifdef ALU_FLAGS_EN
        run8(OP_ADD, 8'h7F, 8'h01, res8, z, lat);
        chk("flags_add_result", 64'(res8), 64'h80);
        chk("flags_add_cvn", 64'({c8, o8, n8}), 64'b011);
        run8(OP_SUB, 8'h00, 8'h01, res8, z, lat);
        chk("flags_sub_result", 64'(res8), 64'hFF);
        chk("flags_sub_cvn", 64'({c8, o8, n8}), 64'b001);
`endif

        // Backpressure: result held while out_ready=0; held request is ignored.
        @(negedge clk); #1;
        rdy64 = 1'b0; v64 = 1'b1; op64 = OP_AND;
        a64 = 64'h0000000AB000000F; b64 = 64'h0002300000000F0F;
        #1;
        chk("bp_in_ready_idle", 64'(ir64), 64'd1);
        @(posedge clk);
        @(negedge clk); #1;
        op64 = OP_OR;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_hold%0d_valid", i), 64'(ov64), 64'd1);
            chk($sformatf("bp_hold%0d_result", i), r64, 64'h000000000000000F);
            chk($sformatf("bp_hold%0d_in_ready", i), 64'(ir64), 64'd0);
            @(negedge clk); #1;
        end
        op64 = OP_ADD; a64 = 64'd1; b64 = 64'd1; rdy64 = 1'b1;
        #1;
        chk("bp_in_ready_consume", 64'(ir64), 64'd1);
        @(posedge clk);
        @(negedge clk); #1;
        v64 = 1'b0;
        chk("bp_next_valid", 64'(ov64), 64'd1);
        chk("bp_next_result", r64, 64'd2);

        // Reset during MUL aborts immediately.
        op64 = OP_MUL; a64 = 64'd7; b64 = 64'd6; v64 = 1'b1;
        #1;
        @(posedge clk); #1;
        v64 = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        chk("mul_busy_valid", 64'(ov64), 64'd0);
        chk("mul_busy_in_ready", 64'(ir64), 64'd0);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(ov64), 64'd0);
        chk("rst_mid_result", r64, 64'd0);
        chk("rst_mid_in_ready", 64'(ir64), 64'd1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run64(OP_MUL, 64'd7, 64'd6, res, z, lat);
        chk("post_rst_mul_result", res, 64'd42);
        chk("post_rst_mul_latency", 64'(lat), 64'd64);

        // Randomised traffic against the reference model.
        for (int i = 0; i < 25; i++) begin
            case ($urandom_range(0, 6))
                0: op = OP_AND;
                1: op = OP_OR;
                2: op = OP_ADD;
                3: op = OP_SUB;
                4: op = OP_NOR;
                5: op = OP_MUL;
                default: op = 4'($urandom_range(0, 15));
            endcase
            x = {$urandom(), $urandom()};
            y = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) == 0) y = x;
            run64(op, x, y, res, z, lat);
            exp = ref_result(64, op, x, y);
            chk($sformatf("rnd64_%0d_op%h_result", i, op), res, exp);
            chk($sformatf("rnd64_%0d_zero", i), 64'(z), 64'(exp == 64'd0));
            chk($sformatf("rnd64_%0d_latency", i), 64'(lat), (op == OP_MUL) ? 64'd64 : 64'd0);
`ifdef ALU_FLAGS_EN
            chk($sformatf("rnd64_%0d_cvn", i), 64'({c64, o64, n64}), 64'(ref_flags(64, op, x, y)));
`endif
        end

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 6))
                0: op = OP_AND;
                1: op = OP_OR;
                2: op = OP_ADD;
                3: op = OP_SUB;
                4: op = OP_NOR;
                5: op = OP_MUL;
                default: op = 4'($urandom_range(0, 15));
            endcase
            x8 = 8'($urandom());
            y8 = 8'($urandom());
            if ($urandom_range(0, 4) == 0) y8 = x8;
            run8(op, x8, y8, res8, z, lat);
            exp = ref_result(8, op, 64'(x8), 64'(y8));
            chk($sformatf("rnd8_%0d_op%h_result", i, op), 64'(res8), exp);
            chk($sformatf("rnd8_%0d_zero", i), 64'(z), 64'(exp == 64'd0));
            chk($sformatf("rnd8_%0d_latency", i), 64'(lat), (op == OP_MUL) ? 64'd8 : 64'd0);
`ifdef ALU_FLAGS_EN
            chk($sformatf("rnd8_%0d_cvn", i), 64'({c8, o8, n8}), 64'(ref_flags(8, op, 64'(x8), 64'(y8))));
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
